// File: rtl/run_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_seq_pkg
// Description : Shared state encoding, default parameters and width helper
//               for the run_sequencer test harness block.
// Revision    : 1.0 - initial release
// ============================================================================
package run_seq_pkg;

    localparam int DEF_DW         = 8;
    localparam int DEF_NREG       = 8;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_RST_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_RST     = 3'd2,
        ST_RUN     = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Index width for n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that stops at LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CW    = 11,
    parameter int LIMIT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] C_LIMIT = CW'(LIMIT);

    // Count enabled cycles; clear wins over enable, and the value never passes LIMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != C_LIMIT)) begin
            count <= count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : run_sequencer
// Description : Preloads a processor register file, holds the processor in
//               reset, lets it run until done or timeout, then scans the
//               register file against masked expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter  int DW         = DEF_DW,
    parameter  int NREG       = DEF_NREG,
    parameter  int TIMEOUT    = DEF_TIMEOUT,
    parameter  int RST_CYCLES = DEF_RST_CYCLES,
    localparam int AW         = idx_width(NREG),
    localparam int CW         = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NREG*DW-1:0] init_vec,
    input  logic [NREG*DW-1:0] expect_vec,
    input  logic [NREG-1:0]  expect_mask,
    output logic             dut_reset,
    input  logic             dut_done,
    output logic             rf_we,
    output logic [AW-1:0]    rf_addr,
    output logic [DW-1:0]    rf_wdata,
    input  logic [DW-1:0]    rf_rdata,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [CW-1:0]    cycles,
    output logic [AW-1:0]    fail_idx
);

    localparam int RCW = idx_width(RST_CYCLES);

    localparam logic [AW-1:0]  C_LAST_IDX = AW'(NREG - 1);
    localparam logic [RCW-1:0] C_RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  C_RUN_LAST = CW'(TIMEOUT - 1);

    state_t         r_state;
    logic [RCW-1:0] r_rst_cnt;

    logic [DW-1:0]  w_init [NREG];
    logic [DW-1:0]  w_exp  [NREG];
    logic           w_accept;
    logic           w_cnt_en;
    logic           w_last_idx;
    logic           w_last_run;
    logic           w_mismatch;
    logic [AW-1:0]  w_next_addr;

    // Flat preload / expect buses viewed as per-register arrays
    for (genvar gi = 0; gi < NREG; gi++) begin : g_unpack
        assign w_init[gi] = init_vec[gi*DW +: DW];
        assign w_exp[gi]  = expect_vec[gi*DW +: DW];
    end

    assign w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_en    = (r_state == ST_RUN) && !dut_done;
    assign w_last_idx  = (rf_addr == C_LAST_IDX);
    assign w_last_run  = (cycles == C_RUN_LAST);
    assign w_next_addr = rf_addr + AW'(1);
    assign w_mismatch  = expect_mask[rf_addr] && (rf_rdata != w_exp[rf_addr]);

    sat_counter #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_run_counter (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (w_accept),
        .enable (w_cnt_en),
        .count  (cycles)
    );

    // Sequencer FSM with every output registered on the state transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rst_cnt <= '0;
            dut_reset <= 1'b1;
            rf_we     <= 1'b0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
            busy      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_PRELOAD;
                        dut_reset <= 1'b1;
                        rf_we     <= 1'b1;
                        rf_addr   <= '0;
                        rf_wdata  <= w_init[0];
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        timeout   <= 1'b0;
                        fail_idx  <= '0;
                    end
                end

                ST_PRELOAD: begin
                    if (w_last_idx) begin
                        r_state   <= ST_RST;
                        rf_we     <= 1'b0;
                        rf_addr   <= '0;
                        r_rst_cnt <= '0;
                    end else begin
                        rf_addr   <= w_next_addr;
                        rf_wdata  <= w_init[w_next_addr];
                    end
                end

                ST_RST: begin
                    if (r_rst_cnt == C_RST_LAST) begin
                        r_state   <= ST_RUN;
                        dut_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end

                // Timeout fires on the edge that brings the counter to TIMEOUT
                ST_RUN: begin
                    if (dut_done) begin
                        r_state <= ST_CHECK;
                        rf_addr <= '0;
                    end else if (w_last_run) begin
                        r_state <= ST_DONE;
                        timeout <= 1'b1;
                        fail    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                // Full scan always runs; only the first mismatch index is kept
                ST_CHECK: begin
                    if (w_mismatch && !fail) begin
                        fail     <= 1'b1;
                        fail_idx <= rf_addr;
                    end
                    if (w_last_idx) begin
                        r_state <= ST_DONE;
                        rf_addr <= '0;
                        busy    <= 1'b0;
                        pass    <= !(fail || w_mismatch);
                    end else begin
                        rf_addr <= w_next_addr;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    dut_reset <= 1'b1;
                    rf_we     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8, register data width.
REQ-002 SHALL have parameter NREG, default 8, register count; AW = clog2(NREG).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum run cycles; CW = clog2(TIMEOUT+1).
REQ-004 SHALL have parameter RST_CYCLES, default 2, processor reset pulse length (>=1).
REQ-005 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  begin a sequence; sampled only in IDLE or DONE.
- init_vec  in  NREG*DW  preload values; slice i goes to register i.
- expect_vec  in  NREG*DW  expected post-run values.
- expect_mask  in  NREG  bit i=1 means register i is compared.
- dut_reset  out  1  active-high reset to processor top level.
- dut_done  in  1  processor completion flag.
- rf_we  out  1  register-file write enable.
- rf_addr  out  AW  register-file address for write and read.
- rf_wdata  out  DW  write data.
- rf_rdata  in  DW  combinational read data for rf_addr.
- busy  out  1  high outside IDLE/DONE.
- pass, fail, timeout  out  1 each  result flags.
- cycles  out  CW  run-cycle count.
- fail_idx  out  AW  lowest mismatching register index.

Function
REQ-006 States SHALL be IDLE, PRELOAD, RST, RUN, CHECK, DONE.
REQ-007 IDLE/DONE + start=1 SHALL go to PRELOAD next edge, clearing pass, fail, timeout, cycles and fail_idx; start in any other state SHALL be ignored.
REQ-008 PRELOAD SHALL write register i (i=0..NREG-1, one per cycle, rf_we=1, rf_addr=i, rf_wdata=init slice i), taking exactly NREG cycles, then go to RST.
REQ-009 dut_reset SHALL be 1 in IDLE, PRELOAD and RST; RST SHALL last exactly RST_CYCLES cycles, then go to RUN.
REQ-010 dut_done SHALL be ignored outside RUN.
REQ-011 RUN SHALL increment cycles each cycle dut_done=0; dut_done=1 SHALL go to CHECK without incrementing (done on the first RUN cycle gives cycles=0).
REQ-012 If cycles reaches TIMEOUT in RUN, the block SHALL set timeout=1, fail=1, skip CHECK and go to DONE; cycles SHALL saturate at TIMEOUT.
REQ-013 CHECK SHALL present rf_addr=i for i=0..NREG-1, one per cycle with rf_we=0, comparing rf_rdata to expect slice i only where expect_mask[i]=1.
REQ-014 On the first mismatch, fail=1 and fail_idx=i SHALL be set; later mismatches SHALL not change fail_idx, and all NREG entries SHALL still be scanned.
REQ-015 After CHECK, pass SHALL be set to 1 iff no mismatch occurred; the block then enters DONE.
REQ-016 DONE SHALL hold all result outputs stable and dut_reset=0 until start.
REQ-017 expect_mask all zero SHALL yield pass=1 once done is observed.
REQ-018 rf_we SHALL be 1 only in PRELOAD.
REQ-019 pass and fail SHALL never both be 1.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, dut_reset=1, rf_we=0, rf_addr=0, busy=0, pass=0, fail=0, timeout=0, cycles=0 and fail_idx=0, in any state including mid-RUN.
REQ-021 The first edge after reset release SHALL observe IDLE; no sequence starts without a new start.

Structure
REQ-022 The state enum and default parameter constants SHALL live in shared package run_seq_pkg.
REQ-023 The saturating run counter SHALL be a sub-module named sat_counter (enable, clear, saturation limit); all else is in run_sequencer.

Verification
REQ-024 init reg4=0x1E, reg2=0x02, others 0; processor done after 37 cycles; expected matches, mask=0xFF -> pass=1, fail=0, cycles=37.
REQ-025 expect reg3 and reg5 differ from actual -> fail=1, fail_idx=3, pass=0, CHECK lasts 8 cycles.
REQ-026 TIMEOUT=16, dut_done never asserted -> timeout=1, fail=1, cycles=16, no CHECK cycles.
REQ-027 reset driven low at RUN cycle 10 -> next observation IDLE, dut_reset=1, all results 0; start pulse during RUN ignored.
REQ-028 dut_done held 1 throughout PRELOAD/RST -> ignored there; first RUN cycle goes to CHECK with cycles=0.
REQ-029 Back-to-back start in DONE -> results cleared, PRELOAD writes NREG entries again.
